fetch_sequencer: RTL and testbench

- Program-counter sequencer and instruction fetch buffer for the single-cycle core's instruction ROM.
- Drives the ROM byte address and captures the combinational ROM word into a registered output.
- Hands instructions to decode over a valid/ready handshake and accepts PC redirects from execute for branches and jumps.
- Sits between the instruction ROM and decode. It is the only driver of the ROM address.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_sequencer.sv | 114 +++++++++++
 tb/tb_fetch_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  localparam int PC_STEP   = 4;
  localparam int INSTR_NOP = 0;

endpackage

// File: rtl/fetch_sequencer.sv
// PC sequencer + one-entry fetch buffer; FETCH_HALT_ON_ZERO_EN halts on an all-zero ROM word.
// Latency: ROM word at pc appears on instr one cycle after pc is on rom_addr; 1 instr/cycle sustained.
// Backpressure: instr_valid & !instr_ready holds instr, instr_pc and pc; redirect flushes regardless.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 8,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter int                       COUNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     halted,
  output logic [COUNT_WIDTH-1:0]   fetch_count
);

  localparam logic [ADDRESS_WIDTH-1:0] PC_RESET = {RESET_PC[ADDRESS_WIDTH-1:2], 2'b00};

  fetch_state_t                 state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]     pc_q;
  logic                         instr_valid_q;
  logic [DATA_WIDTH-1:0]        instr_q;
  logic [ADDRESS_WIDTH-1:0]     instr_pc_q;
  logic [COUNT_WIDTH-1:0]       fetch_count_q;

  logic accept;
  logic redirect_take;
  logic fetch_ok;
  logic halt_hit;
  logic capture;

  always_comb begin
    accept        = instr_valid_q & instr_ready;
    redirect_take = redirect_valid & (state_q != ST_HALTED);
    fetch_ok      = (state_q == ST_RUN) & run & (~instr_valid_q | instr_ready) & ~redirect_valid;
`ifdef FETCH_HALT_ON_ZERO_EN
    halt_hit      = fetch_ok & (rom_data == DATA_WIDTH'(INSTR_NOP));
`else
    halt_hit      = 1'b0;
`endif
    capture       = fetch_ok & ~halt_hit;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_RUN;
      ST_RUN: begin
        if (halt_hit)  state_d = ST_HALTED;
        else if (!run) state_d = ST_IDLE;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Redirect wins over capture and consume: the buffered word is dropped even if accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= PC_RESET;
      instr_valid_q <= 1'b0;
      instr_q       <= DATA_WIDTH'(INSTR_NOP);
      instr_pc_q    <= '0;
    end else if (redirect_take) begin
      pc_q          <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
      instr_valid_q <= 1'b0;
    end else if (capture) begin
      pc_q          <= pc_q + ADDRESS_WIDTH'(PC_STEP);
      instr_valid_q <= 1'b1;
      instr_q       <= rom_data;
      instr_pc_q    <= pc_q;
    end else if (accept) begin
      instr_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       fetch_count_q <= '0;
    else if (accept) fetch_count_q <= fetch_count_q + 1'b1;
  end

`ifdef FETCH_HALT_ON_ZERO_EN
  logic halted_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         halted_q <= 1'b0;
    else if (halt_hit) halted_q <= 1'b1;
  end
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign rom_addr    = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a behavioural fetch model.
module tb_fetch_sequencer;

`ifdef FETCH_HALT_ON_ZERO_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        run;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] rom [64];
  assign rom_data = rom[rom_addr[7:2]];

  fetch_sequencer #(
    .ADDRESS_WIDTH(8), .DATA_WIDTH(32), .RESET_PC(8'h00), .COUNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .run(run),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0=idle 1=run 2=halted
  int          m_mode;
  int          m_pc;
  bit          m_vld;
  logic [31:0] m_instr;
  int          m_ipc;
  int          m_cnt;
  bit          m_halted;

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_vld = 0; m_instr = 0; m_ipc = 0; m_cnt = 0; m_halted = 0;
  endtask

  task automatic model_edge();
    bit acc, redir, fetch_ok, hit;
    logic [31:0] w;
    acc      = m_vld && instr_ready;
    redir    = redirect_valid && (m_mode != 2);
    fetch_ok = (m_mode == 1) && run && (!m_vld || instr_ready) && !redirect_valid;
    w        = rom[m_pc / 4];
    hit      = HALT_EN && fetch_ok && (w == 0);
    if (acc) m_cnt = (m_cnt + 1) % 65536;
    if (redir) begin
      m_pc  = int'(redirect_pc) & 'hFC;
      m_vld = 0;
    end else if (fetch_ok && !hit) begin
      m_instr = w;
      m_ipc   = m_pc;
      m_vld   = 1;
      m_pc    = (m_pc + 4) % 256;
    end else if (acc) begin
      m_vld = 0;
    end
    if (m_mode == 0 && run) m_mode = 1;
    else if (m_mode == 1) begin
      if (hit) begin m_mode = 2; m_halted = 1; end
      else if (!run) m_mode = 0;
    end
  endtask

  task automatic check_model();
    check("rom_addr", 32'(rom_addr), 32'(m_pc));
    check("instr_valid", 32'(instr_valid), 32'(m_vld));
    if (m_vld) begin
      check("instr", instr, m_instr);
      check("instr_pc", 32'(instr_pc), 32'(m_ipc));
    end
    check("fetch_count", 32'(fetch_count), 32'(m_cnt));
    check("halted", 32'(halted), 32'(m_halted));
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic load_rom();
    for (int i = 0; i < 64; i++) rom[i] = $urandom | 32'h1;
    rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 8'h00;
    load_rom();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", 32'(instr_pc), 32'h0);
    check("rst_rom_addr", 32'(rom_addr), 32'h0);
    check("rst_count", 32'(fetch_count), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    reset = 1'b0;

    // Streaming with ready high, then backpressure on 0x22
    run = 1'b1; instr_ready = 1'b1;
    tick();
    tick();
    check("first_instr", instr, 32'h11);
    tick();
    check("second_instr", instr, 32'h22);
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_instr", instr, 32'h22);
      check("bp_instr_pc", 32'(instr_pc), 32'h04);
      check("bp_rom_addr", 32'(rom_addr), 32'h08);
    end
    instr_ready = 1'b1;
    tick();
    check("after_bp_instr", instr, 32'h33);
    check("after_bp_pc", 32'(instr_pc), 32'h08);
    tick();
    check("count_three", 32'(fetch_count), 32'd3);

    // Redirect to an unaligned target while a word is buffered
    redirect_valid = 1'b1; redirect_pc = 8'h43;
    tick();
    check("redir_valid", 32'(instr_valid), 32'h0);
    check("redir_rom_addr", 32'(rom_addr), 32'h40);
    redirect_valid = 1'b0;
    tick();
    check("redir_instr_pc", 32'(instr_pc), 32'h40);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 8'hF8;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    check("wrap_fc", 32'(instr_pc), 32'hFC);
    tick();
    check("wrap_00", 32'(instr_pc), 32'h00);

    // Asynchronous reset mid-stream
    #2 reset = 1'b1;
    #1;
    check("async_valid", 32'(instr_valid), 32'h0);
    check("async_rom_addr", 32'(rom_addr), 32'h0);
    check("async_count", 32'(fetch_count), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Zero word at 0x0C: halt point when the feature is built in, ordinary word otherwise
    rom[3] = 32'h0;
    for (int i = 0; i < 8; i++) tick();
    redirect_valid = 1'b1; redirect_pc = 8'h00;
    tick();
    redirect_valid = 1'b0;
    tick();
    if (HALT_EN) begin
      check("halt_flag", 32'(halted), 32'h1);
      check("halt_rom_addr", 32'(rom_addr), 32'h0C);
      check("halt_count", 32'(fetch_count), 32'd3);
    end else begin
      check("no_halt_flag", 32'(halted), 32'h0);
    end

    // Randomized traffic
    rom[3] = 32'h44;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 600; i++) begin
      run            = ($urandom_range(0, 9) != 0);
      instr_ready    = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = 8'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
